// File: rtl/fpga_mmcm_drp_ctrl.sv
// MMCM reconfiguration controller: holds the MMCM in reset, applies a per-mode table of
// masked read-modify-write DRP updates, then releases reset and waits for lock.
module fpga_mmcm_drp_ctrl #(
    parameter int unsigned N_MODES  = 4,
    parameter int unsigned N_REGS   = 8,
    parameter logic [N_MODES*N_REGS*39-1:0] ROM_INIT = '0,
    parameter int unsigned RST_HOLD = 4,
    parameter int unsigned DRDY_TO  = 64,
    parameter int unsigned LOCK_TO  = 100000
) (
    input  logic        clk_ext,
    input  logic        srst,
    input  logic        req,
    input  logic [1:0]  mode,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        mmcm_rst,
    output logic [6:0]  daddr,
    output logic        den,
    output logic        dwe,
    output logic [15:0] di,
    input  logic [15:0] do_i,
    input  logic        drdy,
    input  logic        pll_lock
);

    localparam int unsigned EntW = 39;
    localparam int unsigned NEnt = N_MODES * N_REGS;
    localparam int unsigned IdxW = (NEnt > 1) ? $clog2(NEnt) : 1;
    localparam int unsigned IW   = (N_REGS > 1) ? $clog2(N_REGS) : 1;
    localparam int unsigned MaxA = (LOCK_TO > DRDY_TO) ? LOCK_TO : DRDY_TO;
    localparam int unsigned MaxT = (MaxA > RST_HOLD) ? MaxA : RST_HOLD;
    localparam int unsigned CntW = $clog2(MaxT + 1);

    typedef enum logic [2:0] {
        StIdle, StRstWait, StRd, StRdWait, StWr, StWrWait, StLockWait, StFinish
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic [IW-1:0]   i_q, i_d;
    logic [1:0]      mode_q, mode_d;
    logic [15:0]     rd_q, rd_d;
    logic            err_q, err_d;
    logic            lock_meta_q, lock_s_q;
    logic            busy_q, busy_d, done_q, done_d, rst_q, rst_d;
    logic            den_q, den_d, dwe_q, dwe_d;
    logic [6:0]      daddr_q, daddr_d;
    logic [15:0]     di_q, di_d;

    logic [EntW-1:0] rom [NEnt];
    for (genvar g = 0; g < NEnt; g++) begin : g_rom
        assign rom[g] = ROM_INIT[g*EntW +: EntW];
    end

    // Table lookup follows the next-state index so addr/data are ready as den is registered.
    logic [IdxW-1:0] ent_idx;
    logic [EntW-1:0] ent;
    logic [6:0]      ent_addr;
    logic [15:0]     ent_mask, ent_data, wr_data;
    assign ent_idx  = IdxW'(mode_d) * IdxW'(N_REGS) + IdxW'(i_d);
    assign ent      = rom[ent_idx];
    assign ent_addr = ent[38:32];
    assign ent_mask = ent[31:16];
    assign ent_data = ent[15:0];
    assign wr_data  = (rd_d & ~ent_mask) | (ent_data & ent_mask);

    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        mode_d  = mode_q;
        rd_d    = rd_q;
        err_d   = err_q;
        cnt_d   = cnt_q + 1'b1;
        unique case (state_q)
            StIdle: begin
                if (req) begin
                    if (32'(mode) < N_MODES) begin
                        mode_d  = mode;
                        err_d   = 1'b0;
                        i_d     = '0;
                        state_d = StRstWait;
                    end else begin
                        err_d   = 1'b1;
                        state_d = StFinish;
                    end
                end
            end
            StRstWait: if (cnt_q == CntW'(RST_HOLD - 1)) state_d = StRd;
            StRd:      state_d = StRdWait;
            StRdWait: begin
                if (drdy) begin
                    rd_d    = do_i;
                    state_d = StWr;
                end else if (cnt_q == CntW'(DRDY_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = StLockWait;
                end
            end
            StWr:      state_d = StWrWait;
            StWrWait: begin
                if (drdy) begin
                    i_d     = i_q + 1'b1;
                    state_d = (i_q == IW'(N_REGS - 1)) ? StLockWait : StRd;
                end else if (cnt_q == CntW'(DRDY_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = StLockWait;
                end
            end
            StLockWait: begin
                if (lock_s_q) begin
                    state_d = StFinish;
                end else if (cnt_q == CntW'(LOCK_TO - 1)) begin
                    err_d   = 1'b1;
                    state_d = StFinish;
                end
            end
            StFinish:  state_d = StIdle;
            default:   state_d = StIdle;
        endcase
        // Every state's timer starts from zero on entry.
        if (state_d != state_q) cnt_d = '0;
    end

    always_comb begin
        busy_d  = (state_d != StIdle) && (state_d != StFinish);
        done_d  = (state_d == StFinish);
        rst_d   = (state_d == StRstWait) || (state_d == StRd) || (state_d == StRdWait) ||
                  (state_d == StWr) || (state_d == StWrWait);
        den_d   = (state_d == StRd) || (state_d == StWr);
        dwe_d   = (state_d == StWr);
        daddr_d = den_d ? ent_addr : daddr_q;
        di_d    = dwe_d ? wr_data : di_q;
    end

    always_ff @(posedge clk_ext) begin
        if (srst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            i_q         <= '0;
            mode_q      <= '0;
            rd_q        <= '0;
            err_q       <= 1'b0;
            lock_meta_q <= 1'b0;
            lock_s_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rst_q       <= 1'b0;
            den_q       <= 1'b0;
            dwe_q       <= 1'b0;
            daddr_q     <= '0;
            di_q        <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            i_q         <= i_d;
            mode_q      <= mode_d;
            rd_q        <= rd_d;
            err_q       <= err_d;
            lock_meta_q <= pll_lock;
            lock_s_q    <= lock_meta_q;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rst_q       <= rst_d;
            den_q       <= den_d;
            dwe_q       <= dwe_d;
            daddr_q     <= daddr_d;
            di_q        <= di_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
    assign mmcm_rst = rst_q;
    assign den      = den_q;
    assign dwe      = dwe_q;
    assign daddr    = daddr_q;
    assign di       = di_q;

endmodule
